vga_frame_scheduler: RTL and testbench

//  Frame-synchronous update scheduler between game logic and the VGA pixel path.
//  - Accepts state/board update requests at any time.
//  - Commits them to the display copies only at the start of vertical blank, so no frame tears.
//  - Blanks the screen for FADE_FRAMES frames when the displayed game state changes.
//  - Produces a frame-locked blink phase for cell/button highlights.
//  - Sits between the game FSM and the VGA top; its *_disp outputs feed the pixel generator.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_frame_scheduler_if.sv | 27 ++
 rtl/vga_frame_tick.sv | 33 +++
 rtl/vga_frame_scheduler.sv | 109 ++++++++++
 tb/tb_vga_frame_scheduler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, game state codes and the update scheduler's state encoding.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned CELLS    = 81;
    localparam int unsigned CELL_W   = 4;
    localparam int unsigned BOARD_W  = CELLS * CELL_W;

    typedef enum logic [1:0] {
        SMENU = 2'd0,
        SGAME = 2'd1,
        SOVER = 2'd2
    } game_state_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_FADE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// Update request bus between the game FSM (master) and the frame scheduler (slave).
interface vga_frame_scheduler_if;
    import vga_pkg::*;

    logic [1:0]         state_in;
    logic [BOARD_W-1:0] board_in;
    logic [CELLS-1:0]   board_blank_in;
    logic               update_req;
    logic               update_ack;

    modport master (
        output state_in,
        output board_in,
        output board_blank_in,
        output update_req,
        input  update_ack
    );

    modport slave (
        input  state_in,
        input  board_in,
        input  board_blank_in,
        input  update_req,
        output update_ack
    );

endinterface

// File: rtl/vga_frame_tick.sv
// Vertical-blank rising-edge detector producing a one-cycle frame tick and a wrapping frame count.
module vga_frame_tick
    import vga_pkg::*;
(
    input  logic       clka,
    input  logic       rst,
    input  logic [9:0] v_cnt_i,
    output logic       frame_tick_o,
    output logic [7:0] frame_cnt_o
);

    logic       vb;
    logic       vb_q;
    logic [7:0] frame_cnt_q;

    assign vb           = (v_cnt_i >= 10'(V_ACTIVE));
    assign frame_tick_o = vb & ~vb_q;
    assign frame_cnt_o  = frame_cnt_q;

    // vb_q resets high so a reset held inside vblank does not produce a spurious tick.
    always_ff @(posedge clka) begin
        if (rst) begin
            vb_q        <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            vb_q <= vb;
            if (frame_tick_o) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Commits game updates to the display copies only at vblank start, with a fade-to-black on
// state changes and a frame-locked blink phase.
module vga_frame_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned FADE_FRAMES  = 8,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic [9:0]            v_cnt,
    vga_frame_scheduler_if.slave  upd,
    output logic [1:0]            state_disp,
    output logic [BOARD_W-1:0]    board_disp,
    output logic [CELLS-1:0]      board_blank_disp,
    output logic                  blank_screen,
    output logic                  blink,
    output logic [7:0]            frame_cnt
);

    logic               frame_tick;
    sched_state_e       state_q;
    logic [7:0]         fade_cnt_q;
    logic [7:0]         blink_cnt_q;
    logic               blink_q;
    logic               blank_screen_q;
    logic               ack_q;
    logic [1:0]         state_disp_q;
    logic [BOARD_W-1:0] board_disp_q;
    logic [CELLS-1:0]   board_blank_disp_q;

    vga_frame_tick u_tick (
        .clka         (clka),
        .rst          (rst),
        .v_cnt_i      (v_cnt),
        .frame_tick_o (frame_tick),
        .frame_cnt_o  (frame_cnt)
    );

    always_ff @(posedge clka) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q            <= S_IDLE;
            fade_cnt_q         <= '0;
            blank_screen_q     <= 1'b0;
            ack_q              <= 1'b0;
            state_disp_q       <= SMENU;
            board_disp_q       <= '0;
            board_blank_disp_q <= '1;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                // A request still high during the ack cycle is the one just served.
                S_IDLE: begin
                    if (upd.update_req && !ack_q) begin
                        state_q <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (frame_tick) begin
                        state_disp_q       <= upd.state_in;
                        board_disp_q       <= upd.board_in;
                        board_blank_disp_q <= upd.board_blank_in;
                        ack_q              <= 1'b1;
                        if (upd.state_in != state_disp_q) begin
                            fade_cnt_q     <= 8'(FADE_FRAMES - 1);
                            blank_screen_q <= 1'b1;
                            state_q        <= S_FADE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_FADE: begin
                    if (frame_tick) begin
                        if (fade_cnt_q == '0) begin
                            blank_screen_q <= 1'b0;
                            state_q        <= S_IDLE;
                        end else begin
                            fade_cnt_q <= fade_cnt_q - 8'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign upd.update_ack   = ack_q;
    assign state_disp       = state_disp_q;
    assign board_disp       = board_disp_q;
    assign board_blank_disp = board_blank_disp_q;
    assign blank_screen     = blank_screen_q;
    assign blink            = blink_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler: directed scenarios plus random traffic against a frame-level model.
module tb_vga_frame_scheduler;
    import vga_pkg::*;

    localparam int unsigned FADE  = 8;
    localparam int unsigned BLINK = 30;

    typedef logic [BOARD_W-1:0] wide_t;

    logic               clka = 1'b0;
    logic               rst  = 1'b1;
    logic [9:0]         v_cnt = '0;
    logic [1:0]         state_disp;
    logic [BOARD_W-1:0] board_disp;
    logic [CELLS-1:0]   board_blank_disp;
    logic               blank_screen;
    logic               blink;
    logic [7:0]         frame_cnt;

    vga_frame_scheduler_if bus ();

    vga_frame_scheduler #(
        .FADE_FRAMES  (FADE),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clka             (clka),
        .rst              (rst),
        .v_cnt            (v_cnt),
        .upd              (bus),
        .state_disp       (state_disp),
        .board_disp       (board_disp),
        .board_blank_disp (board_blank_disp),
        .blank_screen     (blank_screen),
        .blink            (blink),
        .frame_cnt        (frame_cnt)
    );

    always #5 clka = ~clka;

    int n_checks = 0;
    int n_errors = 0;
    int ack_seen = 0;

    task automatic check_eq(input string tag, input wide_t got, input wide_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: frames are counted, fade is an end-tick, blink/frame_cnt are arithmetic.
    logic         m_prev_vb;
    int unsigned  m_ticks;
    int unsigned  m_fade_end;
    bit           m_pending;
    bit           m_ack;
    logic [1:0]   m_state;
    wide_t        m_board;
    logic [CELLS-1:0] m_mask;

    task automatic model_reset();
        m_prev_vb  = 1'b1;
        m_ticks    = 0;
        m_fade_end = 0;
        m_pending  = 1'b0;
        m_ack      = 1'b0;
        m_state    = SMENU;
        m_board    = '0;
        m_mask     = '1;
    endtask

    task automatic step(input logic [9:0] v, input logic r);
        logic vb;
        logic tick;
        bit   fading;
        bit   ack_next;
        rst   = r;
        v_cnt = v;
        if (r) begin
            model_reset();
        end else begin
            vb        = (v >= 10'(V_ACTIVE));
            tick      = vb && !m_prev_vb;
            m_prev_vb = vb;
            fading    = (m_ticks < m_fade_end);
            ack_next  = 1'b0;
            if (tick) m_ticks++;
            if (m_pending && tick) begin
                ack_next  = 1'b1;
                m_pending = 1'b0;
                if (bus.state_in != m_state) m_fade_end = m_ticks + FADE;
                m_state = bus.state_in;
                m_board = bus.board_in;
                m_mask  = bus.board_blank_in;
            end else if (!m_pending && !fading && !m_ack && bus.update_req) begin
                m_pending = 1'b1;
            end
            m_ack = ack_next;
        end
        @(posedge clka);
        #1;
        if (bus.update_ack === 1'b1) ack_seen++;
        check_eq("ack",          wide_t'(bus.update_ack),     wide_t'(m_ack));
        check_eq("state_disp",   wide_t'(state_disp),         wide_t'(m_state));
        check_eq("board_disp",   board_disp,                  m_board);
        check_eq("blank_mask",   wide_t'(board_blank_disp),   wide_t'(m_mask));
        check_eq("blank_screen", wide_t'(blank_screen),       wide_t'(m_ticks < m_fade_end));
        check_eq("blink",        wide_t'(blink),              wide_t'((m_ticks / BLINK) % 2));
        check_eq("frame_cnt",    wide_t'(frame_cnt),          wide_t'(m_ticks % 256));
    endtask

    task automatic random_data();
        bus.state_in = 2'($urandom_range(0, 2));
        for (int i = 0; i < int'(CELLS); i++) begin
            bus.board_in[i*CELL_W +: CELL_W] = 4'($urandom);
            bus.board_blank_in[i]            = 1'($urandom);
        end
    endtask

    task automatic drive_master(input bit random_mode);
        if (bus.update_req && bus.update_ack) begin
            if (!random_mode || $urandom_range(0, 1) == 0) bus.update_req = 1'b0;
        end else if (random_mode) begin
            if (!bus.update_req && $urandom_range(0, 9) == 0) begin
                random_data();
                bus.update_req = 1'b1;
            end else if (bus.update_req && $urandom_range(0, 39) == 0) begin
                bus.update_req = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input bit random_mode);
        int n;
        n = $urandom_range(2, 4);
        for (int k = 0; k < n; k++) begin
            logic [9:0] v;
            v = 10'($urandom_range(0, 479));
            for (int h = 0; h < int'($urandom_range(1, 2)); h++) begin
                drive_master(random_mode);
                step(v, 1'b0);
            end
        end
        for (int h = 0; h < int'($urandom_range(1, 3)); h++) begin
            drive_master(random_mode);
            step(10'd480, 1'b0);
        end
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++) begin
            logic [9:0] v;
            v = 10'($urandom_range(481, 524));
            drive_master(random_mode);
            step(v, 1'b0);
        end
    endtask

    initial begin
        int acks0;
        bus.update_req     = 1'b0;
        bus.state_in       = SMENU;
        bus.board_in       = '0;
        bus.board_blank_in = '0;
        model_reset();

        // Reset held inside vblank, then no tick until v_cnt leaves and re-enters vblank.
        for (int i = 0; i < 3; i++) step(10'd500, 1'b1);
        for (int i = 0; i < 4; i++) step(10'd500, 1'b0);
        check_eq("no_tick_after_reset", wide_t'(frame_cnt), wide_t'(0));
        run_frame(1'b0);
        check_eq("first_tick", wide_t'(frame_cnt), wide_t'(1));

        // Same-state commit: ack appears while v_cnt first sits at 480.
        for (int i = 0; i < 3; i++) step(10'd100, 1'b0);
        bus.state_in        = SMENU;
        bus.board_in        = '0;
        bus.board_in[3:0]   = 4'd5;
        bus.board_blank_in  = '0;
        bus.update_req      = 1'b1;
        for (int i = 0; i < 3; i++) step(10'd100, 1'b0);
        check_eq("no_ack_midframe", wide_t'(bus.update_ack), wide_t'(0));
        step(10'd480, 1'b0);
        check_eq("ack_at_480", wide_t'(bus.update_ack), wide_t'(1));
        check_eq("cell0", wide_t'(board_disp[3:0]), wide_t'(5));
        check_eq("same_state_no_blank", wide_t'(blank_screen), wide_t'(0));
        bus.update_req = 1'b0;
        step(10'd480, 1'b0);
        check_eq("ack_one_cycle", wide_t'(bus.update_ack), wide_t'(0));

        // State change: blank for exactly FADE ticks from the ack edge.
        bus.state_in   = SGAME;
        bus.update_req = 1'b1;
        step(10'd100, 1'b0);
        step(10'd100, 1'b0);
        step(10'd480, 1'b0);
        bus.update_req = 1'b0;
        check_eq("fade_start", wide_t'(blank_screen), wide_t'(1));
        check_eq("state_immediate", wide_t'(state_disp), wide_t'(SGAME));
        for (int f = 0; f < int'(FADE) - 1; f++) run_frame(1'b0);
        check_eq("fade_last_frame", wide_t'(blank_screen), wide_t'(1));
        run_frame(1'b0);
        check_eq("fade_end", wide_t'(blank_screen), wide_t'(0));

        // Request raised two frames into a fade is held off until the fade ends.
        bus.state_in   = SOVER;
        bus.update_req = 1'b1;
        run_frame(1'b0);
        check_eq("fade2_start", wide_t'(blank_screen), wide_t'(1));
        run_frame(1'b0);
        run_frame(1'b0);
        random_data();
        bus.state_in   = SOVER;
        bus.update_req = 1'b1;
        acks0 = ack_seen;
        for (int f = 0; f < int'(FADE) - 2; f++) run_frame(1'b0);
        check_eq("fade2_end", wide_t'(blank_screen), wide_t'(0));
        check_eq("no_ack_in_fade", wide_t'(ack_seen - acks0), wide_t'(0));
        run_frame(1'b0);
        check_eq("ack_after_fade", wide_t'(ack_seen - acks0), wide_t'(1));
        bus.update_req = 1'b0;

        // Reset while pending: no ack, display copies back to reset values.
        bus.state_in   = SGAME;
        bus.update_req = 1'b1;
        for (int i = 0; i < 3; i++) step(10'd100, 1'b0);
        bus.update_req = 1'b0;
        step(10'd100, 1'b1);
        acks0 = ack_seen;
        run_frame(1'b0);
        run_frame(1'b0);
        check_eq("no_ack_after_rst", wide_t'(ack_seen - acks0), wide_t'(0));
        check_eq("state_rst", wide_t'(state_disp), wide_t'(SMENU));
        check_eq("mask_rst", wide_t'(board_blank_disp), wide_t'({CELLS{1'b1}}));

        // Long random run: blink period and frame_cnt wrap past 256 ticks.
        for (int f = 0; f < 300; f++) run_frame(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
